fifo_rd_ctrl: RTL and testbench

Read-side controller for the asynchronous FIFO, running entirely in the destination (read) clock domain. It takes the write pointer after it has crossed into `dest_clk` and been converted back to binary. It then issues reads to the FIFO storage with 1-cycle read latency and presents the data on a valid/ready output through a 2-entry output buffer. It also produces the binary read pointer that crosses back to the write domain.

---
 rtl/fifo_rd_ctrl.sv | 92 +++++++++
 tb/tb_fifo_rd_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: issues storage reads in the dest_clk domain
// and delivers the words through a 2-entry (head + skid) valid/ready output buffer.
module fifo_rd_ctrl #(
   parameter int SIZE   = 5,
   parameter int DATA_W = 8
) (
   input  logic              dest_clk,
   input  logic              rst_n,
   input  logic [SIZE-1:0]   wr_ptr_sync,
   output logic              mem_rd_en,
   output logic [SIZE-2:0]   mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [SIZE-1:0]   rd_ptr,
   output logic              empty,
   output logic [SIZE-1:0]   level,
   output logic              ptr_err
);

   localparam logic [SIZE-1:0] HALF_DEPTH = {1'b1, {(SIZE-1){1'b0}}};
   localparam logic [SIZE-1:0] PTR_ONE    = SIZE'(1);

   logic [SIZE-1:0]   rd_ptr_q;
   logic              inflight;
   logic [1:0]        buf_cnt, buf_cnt_nxt;
   logic [DATA_W-1:0] head, head_nxt;
   logic [DATA_W-1:0] skid, skid_nxt;
   logic              ptr_err_q;
   logic              pop;
   logic [2:0]        pending;

   assign pop         = out_valid & out_ready;
   assign out_valid   = (buf_cnt != 2'd0);
   assign out_data    = head;
   assign rd_ptr      = rd_ptr_q;
   assign ptr_err     = ptr_err_q;
   assign empty       = (rd_ptr_q == wr_ptr_sync);
   assign level       = wr_ptr_sync - rd_ptr_q;
   assign mem_rd_addr = rd_ptr_q[SIZE-2:0];

   // Words already held or on their way, after this cycle's pop; never more than 2.
   assign pending   = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
   assign mem_rd_en = !empty && (pending < 3'd2);

   // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      head_nxt    = head;
      skid_nxt    = skid;
      buf_cnt_nxt = buf_cnt;
      if (pop) begin
         if (buf_cnt == 2'd2) begin
            head_nxt = skid;
            if (inflight) skid_nxt    = mem_rd_data;
            else          buf_cnt_nxt = 2'd1;
         end else begin
            if (inflight) head_nxt    = mem_rd_data;
            else          buf_cnt_nxt = 2'd0;
         end
      end else if (inflight) begin
         if (buf_cnt == 2'd0) begin
            head_nxt    = mem_rd_data;
            buf_cnt_nxt = 2'd1;
         end else begin
            skid_nxt    = mem_rd_data;
            buf_cnt_nxt = 2'd2;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   // NOTE: head/skid are reset too, because out_data must read 0 while the buffer is empty after reset.
   always_ff @(posedge dest_clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q  <= '0;
         inflight  <= 1'b0;
         buf_cnt   <= 2'd0;
         head      <= '0;
         skid      <= '0;
         ptr_err_q <= 1'b0;
      end else begin
         if (mem_rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         inflight  <= mem_rd_en;
         buf_cnt   <= buf_cnt_nxt;
         head      <= head_nxt;
         skid      <= skid_nxt;
         ptr_err_q <= ptr_err_q | (level > HALF_DEPTH);
      end
   end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed scenarios plus a randomized run
// scored against a word-queue / transaction-count model of the read side.
module tb_fifo_rd_ctrl;

   localparam int SIZE   = 5;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << (SIZE - 1);

   logic              dest_clk;
   logic              rst_n;
   logic [SIZE-1:0]   wr_ptr_sync;
   logic              mem_rd_en;
   logic [SIZE-2:0]   mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [SIZE-1:0]   rd_ptr;
   logic              empty;
   logic [SIZE-1:0]   level;
   logic              ptr_err;

   logic [DATA_W-1:0] mem [DEPTH];
   int n_cmp = 0;
   int n_err = 0;

   fifo_rd_ctrl #(.SIZE(SIZE), .DATA_W(DATA_W)) dut (
      .dest_clk    (dest_clk),
      .rst_n       (rst_n),
      .wr_ptr_sync (wr_ptr_sync),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .rd_ptr      (rd_ptr),
      .empty       (empty),
      .level       (level),
      .ptr_err     (ptr_err)
   );

   initial dest_clk = 1'b0;
   always #5 dest_clk = ~dest_clk;

   // Storage with one cycle of read latency.
   always @(posedge dest_clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

   task automatic tick();
      @(posedge dest_clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      wr_ptr_sync = '0;
      out_ready   = 1'b0;
      repeat (2) @(posedge dest_clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wr_ptr_sync = '0; out_ready = 1'b0; mem_rd_data = '0;
      #2;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got %h want 00", out_data); end
      n_cmp++; if (rd_ptr !== 5'd0) begin n_err++; $display("FAIL reset_rd_ptr got %0d want 0", rd_ptr); end
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %0b want 1", empty); end
      n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
      n_cmp++; if (ptr_err !== 1'b0) begin n_err++; $display("FAIL reset_ptr_err got %0b want 0", ptr_err); end
      n_cmp++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_rd_en got %0b want 0", mem_rd_en); end
      do_reset();
   endtask

   task automatic test_single();
      mem[0] = 8'hA5;
      out_ready = 1'b1;
      tick(); wr_ptr_sync = 5'd1; #1;
      n_cmp++; if ({mem_rd_en, mem_rd_addr} !== {1'b1, 4'd0}) begin n_err++; $display("FAIL single_issue got en=%0b addr=%0d want en=1 addr=0", mem_rd_en, mem_rd_addr); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_c0_valid got %0b want 0", out_valid); end
      tick();
      n_cmp++; if ({rd_ptr, empty, mem_rd_en, out_valid} !== {5'd1, 1'b1, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL single_c1 got rd_ptr=%0d empty=%0b en=%0b valid=%0b want 1 1 0 0", rd_ptr, empty, mem_rd_en, out_valid);
      end
      tick();
      n_cmp++; if ({out_valid, out_data} !== {1'b1, 8'hA5}) begin n_err++; $display("FAIL single_c2 got valid=%0b data=%h want 1 a5", out_valid, out_data); end
      tick();
      n_cmp++; if ({out_valid, empty} !== 2'b01) begin n_err++; $display("FAIL single_c3 got valid=%0b empty=%0b want 0 1", out_valid, empty); end
   endtask

   task automatic test_backpressure();
      int n_iss;
      logic [3:0] addrs [4];
      do_reset();
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h10 + i);
      n_iss = 0;
      tick(); wr_ptr_sync = 5'd5; #1;
      for (int c = 0; c < 6; c++) begin
         if (mem_rd_en) begin
            if (n_iss < 4) addrs[n_iss] = mem_rd_addr;
            n_iss++;
         end
         tick();
      end
      n_cmp++; if (n_iss !== 2) begin n_err++; $display("FAIL bp_issue_count got %0d want 2", n_iss); end
      else begin
         n_cmp++; if ({addrs[0], addrs[1]} !== {4'd0, 4'd1}) begin n_err++; $display("FAIL bp_issue_addr got %0d,%0d want 0,1", addrs[0], addrs[1]); end
      end
      n_cmp++; if ({rd_ptr, level} !== {5'd2, 5'd3}) begin n_err++; $display("FAIL bp_ptrs got rd_ptr=%0d level=%0d want 2 3", rd_ptr, level); end
      n_cmp++; if ({out_valid, out_data} !== {1'b1, 8'h10}) begin n_err++; $display("FAIL bp_hold got valid=%0b data=%h want 1 10", out_valid, out_data); end
      out_ready = 1'b1; #1;
      for (int k = 0; k < 5; k++) begin
         n_cmp++; if ({out_valid, out_data} !== {1'b1, 8'(8'h10 + k)}) begin
            n_err++; $display("FAIL bp_stream[%0d] got valid=%0b data=%h want 1 %h", k, out_valid, out_data, 8'(8'h10 + k));
         end
         tick();
      end
      n_cmp++; if ({out_valid, empty, rd_ptr} !== {1'b0, 1'b1, 5'd5}) begin
         n_err++; $display("FAIL bp_end got valid=%0b empty=%0b rd_ptr=%0d want 0 1 5", out_valid, empty, rd_ptr);
      end
   endtask

   task automatic drain_to(input logic [SIZE-1:0] target);
      bit done;
      done = 1'b0;
      out_ready = 1'b1;
      wr_ptr_sync = target;
      for (int c = 0; c < 60 && !done; c++) begin
         tick();
         done = (rd_ptr == target) && !out_valid && !mem_rd_en;
      end
      n_cmp++; if (!done) begin n_err++; $display("FAIL drain_timeout rd_ptr=%0d want %0d", rd_ptr, target); end
   endtask

   task automatic test_wrap();
      logic [3:0]        exp_addr [5];
      logic [SIZE-1:0]   exp_ptr  [5];
      logic [DATA_W-1:0] exp_dat  [5];
      logic [3:0]        got_addr [$];
      logic [SIZE-1:0]   got_ptr  [$];
      logic [DATA_W-1:0] got_dat  [$];
      logic [SIZE-1:0]   last_ptr;
      do_reset();
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h40 + i);
      drain_to(5'd16);
      drain_to(5'd30);
      exp_addr = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
      exp_ptr  = '{5'd31, 5'd0, 5'd1, 5'd2, 5'd3};
      for (int i = 0; i < 5; i++) begin
         exp_dat[i] = 8'($urandom);
         mem[exp_addr[i]] = exp_dat[i];
      end
      last_ptr = rd_ptr;
      wr_ptr_sync = 5'd3; #1;
      n_cmp++; if (level !== 5'd5) begin n_err++; $display("FAIL wrap_level got %0d want 5", level); end
      for (int c = 0; c < 16; c++) begin
         if (mem_rd_en) got_addr.push_back(mem_rd_addr);
         if (out_valid) got_dat.push_back(out_data);
         if (rd_ptr != last_ptr) begin got_ptr.push_back(rd_ptr); last_ptr = rd_ptr; end
         tick();
      end
      n_cmp++; if (got_addr.size() != 5 || got_ptr.size() != 5 || got_dat.size() != 5) begin
         n_err++; $display("FAIL wrap_counts got addr=%0d ptr=%0d data=%0d want 5 5 5", got_addr.size(), got_ptr.size(), got_dat.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({got_addr[i], got_ptr[i], got_dat[i]} !== {exp_addr[i], exp_ptr[i], exp_dat[i]}) begin
               n_err++; $display("FAIL wrap[%0d] got addr=%0d rd_ptr=%0d data=%h want %0d %0d %h",
                                 i, got_addr[i], got_ptr[i], got_dat[i], exp_addr[i], exp_ptr[i], exp_dat[i]);
            end
         end
      end
      n_cmp++; if (ptr_err !== 1'b0) begin n_err++; $display("FAIL wrap_ptr_err got %0b want 0", ptr_err); end
   endtask

   task automatic test_ptr_err();
      do_reset();
      tick(); wr_ptr_sync = 5'd17; #1;
      n_cmp++; if ({level, ptr_err} !== {5'd17, 1'b0}) begin n_err++; $display("FAIL perr_c0 got level=%0d err=%0b want 17 0", level, ptr_err); end
      tick();
      n_cmp++; if (ptr_err !== 1'b1) begin n_err++; $display("FAIL perr_set got %0b want 1", ptr_err); end
      wr_ptr_sync = 5'd0;
      repeat (4) tick();
      n_cmp++; if (ptr_err !== 1'b1) begin n_err++; $display("FAIL perr_sticky got %0b want 1", ptr_err); end
      rst_n = 1'b0; #1;
      n_cmp++; if (ptr_err !== 1'b0) begin n_err++; $display("FAIL perr_reset got %0b want 0", ptr_err); end
      do_reset();
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h70 + i);
      tick(); wr_ptr_sync = 5'd5;
      tick(); tick();
      n_cmp++; if ({out_valid, rd_ptr} !== {1'b1, 5'd2}) begin n_err++; $display("FAIL mid_loaded got valid=%0b rd_ptr=%0d want 1 2", out_valid, rd_ptr); end
      #1 rst_n = 1'b0; wr_ptr_sync = 5'd0; #1;
      n_cmp++; if ({out_valid, out_data, rd_ptr, empty, level, ptr_err, mem_rd_en} !== {1'b1 ^ 1'b1, 8'h00, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL mid_async got valid=%0b data=%h rd_ptr=%0d empty=%0b level=%0d err=%0b en=%0b",
                           out_valid, out_data, rd_ptr, empty, level, ptr_err, mem_rd_en);
      end
      repeat (2) @(posedge dest_clk);
      #1 rst_n = 1'b1; out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_post[%0d] valid got %0b want 0", c, out_valid); end
      end
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] exp_q [$];
      logic [DATA_W-1:0] w;
      int published, issued, consumed, k;
      bit pop, exp_en;
      bit done;
      do_reset();
      published = 0; issued = 0; consumed = 0;
      for (int c = 0; c < 800; c++) begin
         tick();
         out_ready = ($urandom_range(0, 3) != 0);
         k = (c < 700) ? $urandom_range(0, 3) : 0;
         for (int j = 0; j < k; j++) begin
            if (published + 1 - consumed <= DEPTH) begin
               w = 8'($urandom);
               mem[published % DEPTH] = w;
               exp_q.push_back(w);
               published++;
            end
         end
         wr_ptr_sync = SIZE'(published);
         #1;
         pop = out_valid && out_ready;
         exp_en = (published != issued) && (issued - consumed - int'(pop) < 2);
         n_cmp++; if ({rd_ptr, level, empty} !== {SIZE'(issued), SIZE'(published - issued), published == issued}) begin
            n_err++; $display("FAIL rnd_ptrs c=%0d got rd_ptr=%0d level=%0d empty=%0b want %0d %0d %0b",
                              c, rd_ptr, level, empty, SIZE'(issued), SIZE'(published - issued), published == issued);
         end
         n_cmp++; if (mem_rd_en !== exp_en) begin n_err++; $display("FAIL rnd_issue c=%0d got %0b want %0b", c, mem_rd_en, exp_en); end
         if (out_valid) begin
            n_cmp++; if (exp_q.size() == 0 || consumed >= issued) begin
               n_err++; $display("FAIL rnd_spurious_valid c=%0d data=%h want no word", c, out_data);
            end else if (pop) begin
               w = exp_q.pop_front();
               if (out_data !== w) begin n_err++; $display("FAIL rnd_data c=%0d got %h want %h", c, out_data, w); end
            end
         end
         if (mem_rd_en) issued++;
         if (pop) consumed++;
      end
      out_ready = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         tick();
         if (out_valid) begin
            w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            n_cmp++; if (out_data !== w) begin n_err++; $display("FAIL rnd_drain_data got %h want %h", out_data, w); end
         end
         done = (exp_q.size() == 0) && !out_valid && empty;
      end
      n_cmp++; if (!done || ptr_err !== 1'b0) begin
         n_err++; $display("FAIL rnd_drain_end left=%0d empty=%0b err=%0b want 0 1 0", exp_q.size(), empty, ptr_err);
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      test_reset();
      test_single();
      test_backpressure();
      test_wrap();
      test_ptr_err();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
